// File: rtl/fwd_mux_pipe.sv
// Registered N-way operand selector for ALU forwarding: picks one of CHANNELS sources
// and carries it, with valid and effective select, through LATENCY register stages.
module fwd_mux_pipe #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 3,
  parameter int SEL_W    = 2,
  parameter int LATENCY  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          sel_out,
  output logic                      sel_err
);

  localparam logic [SEL_W:0]   CH_N = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  generate
    if (!(LATENCY == 1 || LATENCY == 2) || CHANNELS < 2 || CHANNELS > 8 ||
        CHANNELS > (1 << SEL_W)) begin : g_bad_cfg
      $error("fwd_mux_pipe: illegal LATENCY/CHANNELS/SEL_W combination");
    end
  endgenerate

  function automatic logic sel_oob(input logic [SEL_W-1:0] s);
    return !({1'b0, s} < CH_N);
  endfunction

  // Out-of-range selects alias to the last channel, like the legacy 3-way muxes.
  function automatic logic [SEL_W-1:0] eff_sel(input logic [SEL_W-1:0] s);
    return sel_oob(s) ? LAST : s;
  endfunction

  logic [SEL_W-1:0] eff;
  logic [WIDTH-1:0] sel_data;

  always_comb begin
    eff      = eff_sel(sel);
    sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (eff == SEL_W'(k)) sel_data = data_in[k*WIDTH +: WIDTH];
    end
  end

  // ---- stage 1: capture selected channel ----
  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] sel_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      sel_err <= 1'b0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (!stall) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        data_p1 <= sel_data;
        sel_p1  <= eff;
        if (sel_oob(sel)) sel_err <= 1'b1;
      end
    end
  end

  // ---- stage 2 (LATENCY = 2 only): straight copy of stage 1 ----
  generate
    if (LATENCY == 2) begin : g_lat2
      logic             vld_p2;
      logic [WIDTH-1:0] data_p2;
      logic [SEL_W-1:0] sel_p2;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p2  <= 1'b0;
          data_p2 <= '0;
          sel_p2  <= '0;
        end else if (flush) begin
          vld_p2  <= 1'b0;
          data_p2 <= '0;
        end else if (!stall) begin
          vld_p2  <= vld_p1;
          data_p2 <= data_p1;
          sel_p2  <= sel_p1;
        end
      end

      assign out_valid = vld_p2;
      assign data_out  = data_p2;
      assign sel_out   = sel_p2;
    end else begin : g_lat1
      assign out_valid = vld_p1;
      assign data_out  = data_p1;
      assign sel_out   = sel_p1;
    end
  endgenerate

endmodule

// File: tb/tb_fwd_mux_pipe.sv
// Bench for fwd_mux_pipe: LATENCY=1 and LATENCY=2 instances share stimulus and are
// compared every cycle against a beat-level reference model.
module tb_fwd_mux_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush;
  logic [1:0]  sel;
  logic [47:0] data_in;

  logic [15:0] d1, d2;
  logic        v1, v2, e1, e2;
  logic [1:0]  s1, s2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_mux_pipe #(.WIDTH(16), .CHANNELS(3), .SEL_W(2), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .sel(sel), .data_in(data_in), .data_out(d1), .out_valid(v1), .sel_out(s1),
    .sel_err(e1));

  fwd_mux_pipe #(.WIDTH(16), .CHANNELS(3), .SEL_W(2), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .sel(sel), .data_in(data_in), .data_out(d2), .out_valid(v2), .sel_out(s2),
    .sel_err(e2));

  // Model: slot[0] is the newest beat in flight, slot[1] the one behind it.
  logic        m_vld [2];
  logic [15:0] m_dat [2];
  logic [1:0]  m_sel [2];
  logic        m_err;

  localparam logic [47:0] ABC = {16'hCCCC, 16'hBBBB, 16'hAAAA};

  task automatic model_edge();
    int e;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_vld[i] = 1'b0; m_dat[i] = '0; m_sel[i] = '0;
      end
      m_err = 1'b0;
    end else if (flush) begin
      for (int i = 0; i < 2; i++) begin
        m_vld[i] = 1'b0; m_dat[i] = '0;
      end
    end else if (!stall) begin
      m_vld[1] = m_vld[0]; m_dat[1] = m_dat[0]; m_sel[1] = m_sel[0];
      m_vld[0] = in_valid;
      if (in_valid) begin
        e = (int'(sel) < 3) ? int'(sel) : 2;
        m_dat[0] = 16'(data_in >> (e * 16));
        m_sel[0] = 2'(e);
        if (int'(sel) >= 3) m_err = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("l1_data",  32'(d1), 32'(m_dat[0]));
    chk("l1_valid", 32'(v1), 32'(m_vld[0]));
    chk("l1_sel",   32'(s1), 32'(m_sel[0]));
    chk("l1_err",   32'(e1), 32'(m_err));
    chk("l2_data",  32'(d2), 32'(m_dat[1]));
    chk("l2_valid", 32'(v2), 32'(m_vld[1]));
    chk("l2_sel",   32'(s2), 32'(m_sel[1]));
    chk("l2_err",   32'(e2), 32'(m_err));
  endtask

  task automatic drive(input logic r, input logic v, input logic st, input logic f,
                       input logic [1:0] s);
    rst = r; in_valid = v; stall = st; flush = f; sel = s;
  endtask

  initial begin
    data_in = ABC;
    drive(1, 0, 0, 0, 0);
    step(); step();
    // Hard-coded reset and select expectations on the LATENCY=1 instance
    chk("rst_valid", 32'(v1), 32'd0);
    chk("rst_data",  32'(d1), 32'd0);

    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 2'(i));
      step();
    end
    chk("sel2_data", 32'(d1), 32'h0000CCCC);
    chk("sel2_l2",   32'(d2), 32'h0000BBBB);

    // Out-of-range select, then sticky through beats and flush
    drive(0, 1, 0, 0, 3); step();
    chk("oob_data", 32'(d1), 32'h0000CCCC);
    chk("oob_sel",  32'(s1), 32'd2);
    chk("oob_err",  32'(e1), 32'd1);
    drive(0, 1, 0, 0, 0); step();
    drive(0, 1, 0, 1, 1); step();
    chk("err_after_flush", 32'(e1), 32'd1);
    drive(0, 1, 0, 0, 1); step();

    // Stall with CCCC presented
    drive(1, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0); step();
    drive(0, 1, 0, 0, 1); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 2); step();
      chk("stall_hold", 32'(d1), 32'h0000BBBB);
    end
    drive(0, 1, 0, 0, 2); step();
    chk("after_stall", 32'(d1), 32'h0000CCCC);

    // Flush beats LATENCY=2 pipeline even with stall high
    drive(0, 1, 0, 0, 0); step();
    drive(0, 1, 0, 0, 1); step();
    drive(0, 1, 1, 1, 2); step();
    chk("flush_v2", 32'(v2), 32'd0);
    chk("flush_d2", 32'(d2), 32'd0);
    drive(0, 0, 0, 0, 0); step(); step();

    // LATENCY=2 ordering with a bubble
    drive(1, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    chk("l2_first", 32'(d2), 32'h0000AAAA);
    drive(0, 1, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0); step(); step();
    chk("l2_second", 32'(d2), 32'h0000BBBB);

    // Mid-stream reset
    drive(0, 1, 0, 0, 0); step();
    drive(0, 1, 0, 0, 1); step();
    drive(1, 1, 0, 0, 2); step();
    chk("midrst_v1", 32'(v1), 32'd0);
    drive(0, 1, 0, 0, 2); step();
    drive(0, 0, 0, 0, 0); step(); step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      data_in = {$urandom, $urandom};
      drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
            2'($urandom_range(0, 3)));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_mux_pipe.md
Name: fwd_mux_pipe

Overview:
Parametrised, registered N-way operand selector for the CPU datapath, used mainly for ALU operand forwarding between pipeline stages. It selects one of CHANNELS WIDTH-bit sources and registers the result through 1 or 2 pipeline stages. Each stage carries a valid bit, and the block supports pipeline stall and flush. An out-of-range select aliases to the last channel, and a sticky error flag records when that happens.

Parameters:
WIDTH, 16, data width per channel
CHANNELS, 3, number of input channels (2..8)
SEL_W, 2, select width; must satisfy 2^SEL_W >= CHANNELS
LATENCY, 1, register stages between input and output (1 or 2 only)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input beat is valid this cycle
stall  in  1  freeze all stages
flush  in  1  kill all in-flight beats
sel  in  SEL_W  channel select
data_in  in  CHANNELS*WIDTH  packed sources; channel k occupies bits [k*WIDTH +: WIDTH]
data_out  out  WIDTH  registered selected data from the last stage
out_valid  out  1  data_out holds a valid beat
sel_out  out  SEL_W  effective channel index of the beat in the last stage, after aliasing
sel_err  out  1  sticky flag: an accepted beat had sel >= CHANNELS

Behaviour:
- All state updates on the rising edge of clk. No combinational path from inputs to outputs.
- Effective select: eff = sel if sel < CHANNELS, else CHANNELS-1. This is the same default-to-last rule as the existing 3-way muxes.
- Priority per cycle: rst > flush > stall > normal advance.
- Reset (synchronous, active-high): all stage data = 0, all stage valid = 0, all stage sel = 0, sel_err = 0. Outputs read 0 on the first edge after rst is sampled high. Reset mid-operation discards every in-flight beat.
- Flush (rst low): all stage valid = 0 and all stage data = 0 on that edge, even if stall is high. The input beat presented in the flush cycle is discarded. sel_err is not cleared by flush.
- Stall (rst and flush low): every stage register holds, including valid, data, sel and sel_err. The input beat is not accepted.
- Normal advance:
  - Stage 1 captures valid = in_valid.
  - If in_valid = 1, stage 1 also captures data = data_in[eff], sel = eff.
  - If in_valid = 0, stage 1 data and sel hold their previous values.
  - With LATENCY = 2, stage 2 copies all of stage 1 (valid, data, sel) on the same edge.
- Latency: a beat accepted at edge n appears on the outputs after edge n for LATENCY = 1, and after edge n+1 for LATENCY = 2. Throughput is one beat per cycle when not stalled.
- sel_err: set on a normal-advance edge when in_valid = 1 and sel >= CHANNELS. It stays set until rst; flush does not clear it. It is never set while stalled or flushed.
- Outputs are driven directly from the last stage registers.
- Unsupported LATENCY values or CHANNELS > 2^SEL_W are illegal configurations. Guard them with a generate-time error.

Test Plan:
1. Reset, then select each channel: WIDTH=16, CHANNELS=3, LATENCY=1; data_in = {16'hCCCC, 16'hBBBB, 16'hAAAA}; sel = 0, 1, 2 on consecutive cycles with in_valid=1 -> data_out = AAAA, BBBB, CCCC one cycle later each; out_valid=1; sel_out = 0, 1, 2.
2. Out-of-range select: sel = 3 with in_valid=1 -> data_out = CCCC, sel_out = 2, sel_err = 1. sel_err stays 1 through later valid beats and through a flush. Only rst clears it.
3. Stall: stream AAAA, BBBB; raise stall for 3 cycles while presenting CCCC -> data_out holds BBBB and out_valid holds 1 throughout. CCCC is not captured and sel_err is unchanged. After stall drops, the next accepted beat appears normally.
4. Flush priority: with LATENCY=2 and two valid beats in flight, assert flush and stall together -> next edge out_valid = 0, data_out = 0. Neither in-flight beat nor the flush-cycle input ever appears on the outputs.
5. Latency-2 ordering: LATENCY=2, beats AAAA, then a bubble (in_valid=0), then BBBB -> out_valid pattern 0, 0, 1, 0, 1, with data AAAA at cycle 2 and BBBB at cycle 4.
6. Mid-stream reset: assert rst for 1 cycle during a stream -> all outputs 0 the following cycle; the stream resumes cleanly on the next accepted beat.
